// File: rtl/intr_pkg.sv
// Shared types and helpers for the push-button interrupt generator.
package intr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DB_PRESS,
    PULSE,
    HELD,
    DB_RELEASE
  } intr_state_t;

  // The one counter times both the debounce windows and the pulse, so size it for the longer of the two.
  function automatic int cnt_width(input int db_count, input int pulse_cycles);
    int longest;
    longest = (db_count > pulse_cycles) ? db_count : pulse_cycles;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for any asynchronous external input (buttons, switches, IOBUS lines).
module sync_2ff (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic q
);

  logic s1;
  logic s2;

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  assign q = s2;

endmodule

// File: rtl/intr_button_debouncer.sv
// Turns a bouncing push-button into one fixed-width INTR pulse per debounced press for the MCU.
module intr_button_debouncer
  import intr_pkg::*;
#(
  parameter int DB_COUNT     = 500000,
  parameter int PULSE_CYCLES = 4,
  parameter int CNT_W        = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             BTN,
  output logic             INTR,
  output logic             BUSY,
  output logic [CNT_W-1:0] EVENT_CNT
);

  localparam int CW = cnt_width(DB_COUNT, PULSE_CYCLES);
  localparam logic [CW-1:0] DB_LAST    = CW'(DB_COUNT - 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);

  intr_state_t      state;
  intr_state_t      next_state;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    next_cnt;
  logic             s2;
  logic             intr_d;
  logic             busy_d;
  logic             event_inc;
  logic             intr_q;
  logic             busy_q;
  logic [CNT_W-1:0] event_cnt;

  sync_2ff u_sync (
    .CLK (CLK),
    .RST (RST),
    .d   (BTN),
    .q   (s2)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    unique case (state)
      IDLE: begin
        if (s2) begin
          next_state = DB_PRESS;
          next_cnt   = '0;
        end
      end
      DB_PRESS: begin
        if (!s2) begin
          next_state = IDLE;
          next_cnt   = '0;
        end else if (cnt == DB_LAST) begin
          next_state = PULSE;
          next_cnt   = '0;
        end else begin
          next_cnt = cnt + CW'(1);
        end
      end
      // The button is deliberately ignored here so a release cannot shorten the pulse.
      PULSE: begin
        if (cnt == PULSE_LAST) begin
          next_state = HELD;
          next_cnt   = '0;
        end else begin
          next_cnt = cnt + CW'(1);
        end
      end
      HELD: begin
        if (!s2) begin
          next_state = DB_RELEASE;
          next_cnt   = '0;
        end
      end
      DB_RELEASE: begin
        if (s2) begin
          next_state = HELD;
          next_cnt   = '0;
        end else if (cnt == DB_LAST) begin
          next_state = IDLE;
          next_cnt   = '0;
        end else begin
          next_cnt = cnt + CW'(1);
        end
      end
      default: begin
        next_state = IDLE;
        next_cnt   = '0;
      end
    endcase
  end

  // Outputs are decoded from next_state and registered, so INTR/BUSY track the state with no decode glitches.
  always_comb begin
    intr_d    = (next_state == PULSE);
    busy_d    = (next_state != IDLE);
    event_inc = (state == DB_PRESS) && (next_state == PULSE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      intr_q    <= 1'b0;
      busy_q    <= 1'b0;
      event_cnt <= '0;
    end else begin
      intr_q <= intr_d;
      busy_q <= busy_d;
      if (event_inc) begin
        event_cnt <= event_cnt + CNT_W'(1);
      end
    end
  end

  assign INTR      = intr_q;
  assign BUSY      = busy_q;
  assign EVENT_CNT = event_cnt;

endmodule

// File: tb/tb_intr_button_debouncer.sv
// Directed bench: expected pulses are queued as presses are driven and matched when INTR rises.
module tb_intr_button_debouncer;

  localparam int DB    = 4;
  localparam int PC    = 3;
  localparam int CNTW  = 8;
  localparam int LAT   = DB + 3;

  typedef struct {
    int rise_edge;
    int cnt;
  } exp_pulse_t;

  logic            clk;
  logic            rst;
  logic            btn;
  logic            intr;
  logic            busy;
  logic [CNTW-1:0] event_cnt;

  int         total;
  int         bad;
  int         edge_no;
  int         model_cnt;
  int         pulse_len;
  logic       prev_intr;
  logic       in_pulse;
  exp_pulse_t exp_q[$];

  intr_button_debouncer #(
    .DB_COUNT     (DB),
    .PULSE_CYCLES (PC),
    .CNT_W        (CNTW)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .BTN       (btn),
    .INTR      (intr),
    .BUSY      (busy),
    .EVENT_CNT (event_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one edge, sample 1ns later, and score any INTR pulse against the queue.
  task automatic tick();
    exp_pulse_t p;
    @(posedge clk);
    #1;
    edge_no++;
    if (rst) begin
      in_pulse  = 1'b0;
      pulse_len = 0;
    end else if (intr && !prev_intr) begin
      check_output("pulse_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        p = exp_q.pop_front();
        check_output("pulse_rise_edge", 32'(edge_no), 32'(p.rise_edge));
        check_output("pulse_event_cnt", 32'(event_cnt), 32'(p.cnt));
      end
      in_pulse  = 1'b1;
      pulse_len = 1;
    end else if (intr) begin
      pulse_len++;
    end else if (prev_intr && in_pulse) begin
      check_output("pulse_len", 32'(pulse_len), 32'(PC));
      in_pulse = 1'b0;
    end
    prev_intr = intr;
  endtask

  task automatic push_expected();
    exp_pulse_t p;
    model_cnt   = (model_cnt + 1) % (1 << CNTW);
    p.rise_edge = edge_no + LAT;
    p.cnt       = model_cnt;
    exp_q.push_back(p);
  endtask

  task automatic apply_stimulus(input logic level, input int cycles, input bit expect_pulse);
    if (expect_pulse) push_expected();
    btn = level;
    repeat (cycles) tick();
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) tick();
    model_cnt = 0;
    rst = 1'b0;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    edge_no   = 0;
    model_cnt = 0;
    pulse_len = 0;
    prev_intr = 1'b0;
    in_pulse  = 1'b0;
    btn       = 1'b0;
    rst       = 1'b1;

    do_reset(2);
    check_output("reset_intr", 32'(intr), 32'd0);
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_event_cnt", 32'(event_cnt), 32'd0);
    repeat (2) tick();

    $display("[TB] clean press");
    apply_stimulus(1'b1, 2, 1'b1);
    check_output("clean_busy_e2", 32'(busy), 32'd0);
    tick();
    check_output("clean_busy_e3", 32'(busy), 32'd1);
    repeat (3) tick();
    check_output("clean_intr_e6", 32'(intr), 32'd0);
    tick();
    check_output("clean_intr_e7", 32'(intr), 32'd1);
    repeat (3) tick();
    check_output("clean_intr_e10", 32'(intr), 32'd0);
    repeat (10) tick();
    check_output("clean_event_cnt", 32'(event_cnt), 32'(model_cnt));
    apply_stimulus(1'b0, 6, 1'b0);
    check_output("clean_release_busy_e6", 32'(busy), 32'd1);
    tick();
    check_output("clean_release_busy_e7", 32'(busy), 32'd0);
    repeat (3) tick();

    $display("[TB] press bounce");
    apply_stimulus(1'b1, 3, 1'b0);
    apply_stimulus(1'b0, 10, 1'b0);
    check_output("bounce3_busy", 32'(busy), 32'd0);
    apply_stimulus(1'b1, DB, 1'b0);
    apply_stimulus(1'b0, 10, 1'b0);
    check_output("bounce4_busy", 32'(busy), 32'd0);
    check_output("bounce_event_cnt", 32'(event_cnt), 32'(model_cnt));

    // One cycle past the debounce window: accepted, and the early release must not cut the pulse short.
    apply_stimulus(1'b1, DB + 1, 1'b1);
    apply_stimulus(1'b0, 20, 1'b0);
    check_output("short_press_busy", 32'(busy), 32'd0);
    check_output("short_press_event_cnt", 32'(event_cnt), 32'(model_cnt));

    $display("[TB] long hold");
    apply_stimulus(1'b1, 100, 1'b1);
    check_output("hold_event_cnt", 32'(event_cnt), 32'(model_cnt));
    check_output("hold_busy", 32'(busy), 32'd1);
    apply_stimulus(1'b0, 6, 1'b0);
    check_output("hold_release_busy_e6", 32'(busy), 32'd1);
    tick();
    check_output("hold_release_busy_e7", 32'(busy), 32'd0);
    repeat (3) tick();

    $display("[TB] release bounce");
    apply_stimulus(1'b1, 12, 1'b1);
    apply_stimulus(1'b0, 2, 1'b0);
    apply_stimulus(1'b1, 2, 1'b0);
    apply_stimulus(1'b0, 2, 1'b0);
    apply_stimulus(1'b1, 2, 1'b0);
    apply_stimulus(1'b0, 6, 1'b0);
    check_output("relbounce_busy_e14", 32'(busy), 32'd1);
    tick();
    check_output("relbounce_busy_e15", 32'(busy), 32'd0);
    repeat (13) tick();
    apply_stimulus(1'b1, 12, 1'b1);
    apply_stimulus(1'b0, 10, 1'b0);
    check_output("relbounce_event_cnt", 32'(event_cnt), 32'(model_cnt));

    $display("[TB] reset mid-pulse");
    apply_stimulus(1'b1, LAT + 1, 1'b1);
    check_output("rstpulse_intr_before", 32'(intr), 32'd1);
    do_reset(1);
    check_output("rstpulse_intr", 32'(intr), 32'd0);
    check_output("rstpulse_event_cnt", 32'(event_cnt), 32'd0);
    check_output("rstpulse_busy", 32'(busy), 32'd0);
    apply_stimulus(1'b1, 12, 1'b1);
    check_output("rstpulse_event_cnt_after", 32'(event_cnt), 32'd1);
    apply_stimulus(1'b0, 10, 1'b0);

    $display("[TB] event counter wrap");
    do_reset(1);
    for (int i = 0; i < (1 << CNTW); i++) begin
      apply_stimulus(1'b1, 12, 1'b1);
      apply_stimulus(1'b0, 10, 1'b0);
      if (i == (1 << CNTW) - 2) begin
        check_output("wrap_event_cnt_max", 32'(event_cnt), 32'((1 << CNTW) - 1));
      end
    end
    check_output("wrap_event_cnt_zero", 32'(event_cnt), 32'd0);
    apply_stimulus(1'b1, 12, 1'b1);
    apply_stimulus(1'b0, 10, 1'b0);
    check_output("wrap_event_cnt_one", 32'(event_cnt), 32'd1);

    check_output("pulses_outstanding", 32'(exp_q.size()), 32'd0);
    check_output("final_intr", 32'(intr), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
